// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - round-robin arbiter emitting a binary grant index with valid/ready handshake
// Optional ARB_LOCK_EN adds a 'lock' input that re-grants the current holder while it keeps requesting.
module rr_index_arbiter #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   req,
    input  logic              gnt_ready,
`ifdef ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic              gnt_valid,
    output logic [N-1:0]      gnt_idx,
    output logic              busy
);

    localparam int W = 2**N;
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state;
    logic [N-1:0] ptr;
    logic [N-1:0] next_base;
    logic [N-1:0] win_ptr;
    logic [N-1:0] win_next;
    logic         any_req;
    logic         hold;

    // First set bit scanning upward from base, wrapping in N-bit index space.
    function automatic logic [N-1:0] winner(input logic [W-1:0] r, input logic [N-1:0] base);
        logic [N-1:0] idx;
        logic [N-1:0] w;
        logic         found;
        idx   = base;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
            idx = idx + ONE;
        end
        return w;
    endfunction

    assign any_req   = |req;
    assign next_base = gnt_idx + ONE;
    assign win_ptr   = winner(req, ptr);
    assign win_next  = winner(req, next_base);

`ifdef ARB_LOCK_EN
    assign hold = lock & req[gnt_idx];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_idx   <= win_ptr;
                        state     <= GRANT;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    // gnt_idx stays frozen until the consumer takes it
                    if (gnt_ready && !hold) begin
                        ptr <= next_base;
                        if (any_req) begin
                            gnt_idx <= win_next;
                        end else begin
                            state     <= IDLE;
                            gnt_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb/tb_rr_index_arbiter.sv - directed self-checking bench for rr_index_arbiter (N=3)
module tb_rr_index_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       gnt_ready;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       busy;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    rr_index_arbiter #(.N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_ready (gnt_ready),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .busy      (busy)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        assertions++;
        if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b exp 0", gnt_valid); end
        assertions++;
        if (gnt_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got %0d exp 0", gnt_idx); end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b exp 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        req = 8'h10;
        gnt_ready = 1'b0;
        step;
        assertions++;
        if (gnt_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL single_valid got v=%0b b=%0b exp 1/1", gnt_valid, busy);
        end
        assertions++;
        if (gnt_idx !== 3'd4) begin failures++; $display("FAIL single_idx got %0d exp 4", gnt_idx); end
        for (int i = 0; i < 5; i++) begin
            step;
            assertions++;
            if (gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
                failures++; $display("FAIL single_hold cycle %0d got idx=%0d v=%0b exp 4/1", i, gnt_idx, gnt_valid);
            end
        end
    endtask

    task automatic test_reset_mid_grant;
        #2 rst = 1'b1;
        #1;
        assertions++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL async_reset got v=%0b idx=%0d b=%0b exp 0/0/0", gnt_valid, gnt_idx, busy);
        end
        step;
        rst = 1'b0;
        req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step;
            assertions++;
            if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || busy !== 1'b0) begin
                failures++; $display("FAIL post_reset_idle cycle %0d got v=%0b idx=%0d b=%0b exp 0/0/0", i, gnt_valid, gnt_idx, busy);
            end
        end
    endtask

    task automatic test_rotation;
        req = 8'hFF;
        gnt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step;
            assertions++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(i % 8)) begin
                failures++; $display("FAIL rotation step %0d got idx=%0d v=%0b exp %0d/1", i, gnt_idx, gnt_valid, i % 8);
            end
        end
        req = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step;
            assertions++;
            if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_idx !== 3'd0) begin
                failures++; $display("FAIL idle_keep cycle %0d got v=%0b b=%0b idx=%0d exp 0/0/0", i, gnt_valid, busy, gnt_idx);
            end
        end
    endtask

    task automatic test_wrap;
        req = 8'h40;
        gnt_ready = 1'b1;
        step;
        assertions++;
        if (gnt_idx !== 3'd6 || gnt_valid !== 1'b1) begin failures++; $display("FAIL wrap_setup got idx=%0d v=%0b exp 6/1", gnt_idx, gnt_valid); end
        req = 8'h00;
        step;
        assertions++;
        if (gnt_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle got v=%0b exp 0", gnt_valid); end
        req = 8'h81;
        gnt_ready = 1'b0;
        step;
        assertions++;
        if (gnt_idx !== 3'd7 || gnt_valid !== 1'b1) begin failures++; $display("FAIL wrap_first got idx=%0d v=%0b exp 7/1", gnt_idx, gnt_valid); end
        gnt_ready = 1'b1;
        step;
        assertions++;
        if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin failures++; $display("FAIL wrap_second got idx=%0d v=%0b exp 0/1", gnt_idx, gnt_valid); end
        step;
        assertions++;
        if (gnt_idx !== 3'd7 || gnt_valid !== 1'b1) begin failures++; $display("FAIL wrap_third got idx=%0d v=%0b exp 7/1", gnt_idx, gnt_valid); end
        req = 8'h00;
        step;
        assertions++;
        if (gnt_valid !== 1'b0) begin failures++; $display("FAIL wrap_end got v=%0b exp 0", gnt_valid); end
    endtask

    task automatic test_stability;
        req = 8'h04;
        gnt_ready = 1'b0;
        step;
        assertions++;
        if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin failures++; $display("FAIL stab_grant got idx=%0d v=%0b exp 2/1", gnt_idx, gnt_valid); end
        req = 8'h20;
        for (int i = 0; i < 3; i++) begin
            step;
            assertions++;
            if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
                failures++; $display("FAIL stab_hold cycle %0d got idx=%0d v=%0b exp 2/1", i, gnt_idx, gnt_valid);
            end
        end
        gnt_ready = 1'b1;
        step;
        assertions++;
        if (gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin failures++; $display("FAIL stab_next got idx=%0d v=%0b exp 5/1", gnt_idx, gnt_valid); end
        req = 8'h00;
        step;
        assertions++;
        if (gnt_valid !== 1'b0) begin failures++; $display("FAIL stab_end got v=%0b exp 0", gnt_valid); end
    endtask

    task automatic test_back_to_back;
        req = 8'h08;
        gnt_ready = 1'b1;
        step;
        assertions++;
        if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin failures++; $display("FAIL sole_first got idx=%0d v=%0b exp 3/1", gnt_idx, gnt_valid); end
        step;
        assertions++;
        if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin failures++; $display("FAIL sole_regrant got idx=%0d v=%0b exp 3/1", gnt_idx, gnt_valid); end
        req = 8'h00;
        step;
        assertions++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL sole_end got v=%0b b=%0b exp 0/0", gnt_valid, busy); end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock;
        req = 8'h0C;
        lock = 1'b1;
        gnt_ready = 1'b0;
        step;
        assertions++;
        if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin failures++; $display("FAIL lock_grant got idx=%0d v=%0b exp 2/1", gnt_idx, gnt_valid); end
        gnt_ready = 1'b1;
        step;
        assertions++;
        if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin failures++; $display("FAIL lock_hold got idx=%0d v=%0b exp 2/1", gnt_idx, gnt_valid); end
        lock = 1'b0;
        step;
        assertions++;
        if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin failures++; $display("FAIL lock_release got idx=%0d v=%0b exp 3/1", gnt_idx, gnt_valid); end
        req = 8'h00;
        step;
        assertions++;
        if (gnt_valid !== 1'b0) begin failures++; $display("FAIL lock_end got v=%0b exp 0", gnt_valid); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 8'h00;
        gnt_ready = 1'b0;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        test_reset;
        test_single;
        test_reset_mid_grant;
        test_rotation;
        test_wrap;
        test_stability;
        test_back_to_back;
`ifdef ARB_LOCK_EN
        test_lock;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
